// File: rtl/adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
// Holds the control state encoding and the step-count helper.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int unsigned steps(input int unsigned width, input int unsigned digit);
      return width / digit;
   endfunction

endpackage

// File: rtl/fa_slice.sv
// Combinational DIGIT-bit ripple of full adders.
// Also exposes the carry into the top bit for signed-overflow detection.
module fa_slice #(
   parameter int unsigned DIGIT = 1
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             c_msb_in
);

   logic [DIGIT:0] w_c;

   always_comb begin
      w_c    = '0;
      s      = '0;
      w_c[0] = ci;
      for (int unsigned i = 0; i < DIGIT; i++) begin
         s[i]     = x[i] ^ y[i] ^ w_c[i];
         w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
      end
   end

   assign co       = w_c[DIGIT];
   assign c_msb_in = w_c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: sum = a + b + cin, DIGIT bits per clock,
// with valid/ready handshakes on operand and result sides.
module serial_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned STEPS = steps(WIDTH, DIGIT);
   localparam int unsigned CNT_W = $clog2(STEPS + 1);

   if ((WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("serial_adder: DIGIT must divide WIDTH");
   end

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_sum;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_carry;
   logic               r_cout;
   logic               r_ovf;

   logic [DIGIT-1:0]   w_s;
   logic               w_co;
   logic               w_c_msb;
   logic               w_last;

   fa_slice #(.DIGIT(DIGIT)) u_fa_slice (
      .x        (r_a[DIGIT-1:0]),
      .y        (r_b[DIGIT-1:0]),
      .ci       (r_carry),
      .s        (w_s),
      .co       (w_co),
      .c_msb_in (w_c_msb)
   );

   assign w_last = (r_cnt == CNT_W'(STEPS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_state_nxt = RUN;
         RUN:     if (w_last)    w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default:                w_state_nxt = IDLE;
      endcase
   end

   // Result bits enter at the top so the LSB digit ends up at bit 0 after STEPS shifts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= cin;
                  r_cnt   <= '0;
               end
            end
            RUN: begin
               r_sum   <= WIDTH'({w_s, r_sum} >> DIGIT);
               r_a     <= r_a >> DIGIT;
               r_b     <= r_b >> DIGIT;
               r_carry <= w_co;
               r_cnt   <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_cout <= w_co;
                  r_ovf  <= w_c_msb ^ w_co;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder in three configurations:
// W1/D1 (index 0), W8/D1 (index 1), W8/D4 (index 2).
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] in_valid;
   logic [2:0] out_ready;
   logic [2:0] cin;
   logic [2:0] in_ready;
   logic [2:0] out_valid;
   logic [2:0] cout;
   logic [2:0] ovf;
   logic       a1, b1, s1;
   logic [7:0] a81, b81, s81;
   logic [7:0] a84, b84, s84;
   int         n_cmp;
   int         n_fail;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(1), .DIGIT(1)) u_w1d1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .a(a1), .b(b1), .cin(cin[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .sum(s1), .cout(cout[0]), .ovf(ovf[0])
   );

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .a(a81), .b(b81), .cin(cin[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .sum(s81), .cout(cout[1]), .ovf(ovf[1])
   );

   serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .a(a84), .b(b84), .cin(cin[2]), .out_valid(out_valid[2]),
      .out_ready(out_ready[2]), .sum(s84), .cout(cout[2]), .ovf(ovf[2])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] get_sum(input int id);
      case (id)
         0:       return {7'd0, s1};
         1:       return s81;
         default: return s84;
      endcase
   endfunction

   task automatic set_ops(input int id, input logic [7:0] av, input logic [7:0] bv);
      case (id)
         0:       begin a1  = av[0]; b1  = bv[0]; end
         1:       begin a81 = av;    b81 = bv;    end
         default: begin a84 = av;    b84 = bv;    end
      endcase
   endtask

   // Reference: plain integer addition, signed overflow from operand/result signs.
   task automatic do_op(input int id, input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input int hold);
      int         st;
      int         cycles;
      logic [8:0] full;
      logic [7:0] mask;
      logic [7:0] exp_sum;
      logic       exp_cout, exp_ovf, sa, sb, ss;
      st       = (id == 0) ? 1 : ((id == 1) ? 8 : 2);
      mask     = (id == 0) ? 8'h01 : 8'hFF;
      full     = 9'(av & mask) + 9'(bv & mask) + 9'(cv);
      exp_sum  = full[7:0] & mask;
      exp_cout = (id == 0) ? full[1] : full[8];
      sa       = (id == 0) ? av[0] : av[7];
      sb       = (id == 0) ? bv[0] : bv[7];
      ss       = (id == 0) ? exp_sum[0] : exp_sum[7];
      exp_ovf  = (sa == sb) && (ss != sa);

      chk("in_ready_idle", 32'(in_ready[id]), 32'd1);
      set_ops(id, av, bv);
      cin[id]      = cv;
      in_valid[id] = 1'b1;
      @(posedge clk); #1;
      in_valid[id] = 1'b0;
      set_ops(id, ~av, ~bv);
      cin[id] = ~cv;
      cycles = 0;
      while (out_valid[id] !== 1'b1 && cycles < 64) begin
         @(posedge clk); #1;
         cycles++;
      end
      chk("latency", 32'(cycles), 32'(st));
      chk("sum", 32'(get_sum(id)), 32'(exp_sum));
      chk("cout", 32'(cout[id]), 32'(exp_cout));
      chk("ovf", 32'(ovf[id]), 32'(exp_ovf));
      chk("in_ready_done", 32'(in_ready[id]), 32'd0);
      for (int i = 0; i < hold; i++) begin
         in_valid[id] = 1'b1;
         @(posedge clk); #1;
         in_valid[id] = 1'b0;
         chk("bp_valid", 32'(out_valid[id]), 32'd1);
         chk("bp_sum", 32'(get_sum(id)), 32'(exp_sum));
         chk("bp_cout", 32'(cout[id]), 32'(exp_cout));
         chk("bp_in_ready", 32'(in_ready[id]), 32'd0);
      end
      out_ready[id] = 1'b1;
      @(posedge clk); #1;
      out_ready[id] = 1'b0;
      chk("release_valid", 32'(out_valid[id]), 32'd0);
      chk("release_in_ready", 32'(in_ready[id]), 32'd1);
   endtask

   initial begin
      n_cmp     = 0;
      n_fail    = 0;
      rst       = 1'b1;
      in_valid  = '0;
      out_ready = '0;
      cin       = '0;
      a1 = 1'b0; b1 = 1'b0; a81 = '0; b81 = '0; a84 = '0; b84 = '0;
      #1;
      for (int id = 0; id < 3; id++) begin
         chk("rst_out_valid", 32'(out_valid[id]), 32'd0);
         chk("rst_in_ready", 32'(in_ready[id]), 32'd1);
         chk("rst_sum", 32'(get_sum(id)), 32'd0);
         chk("rst_cout", 32'(cout[id]), 32'd0);
         chk("rst_ovf", 32'(ovf[id]), 32'd0);
      end

      // A handshake while reset is held must not start an operation.
      in_valid[2] = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid[2] = 1'b0;
      @(posedge clk); #1;
      chk("void_hs_in_ready", 32'(in_ready[2]), 32'd1);
      chk("void_hs_out_valid", 32'(out_valid[2]), 32'd0);

      for (int k = 0; k < 8; k++) begin
         logic [2:0] v;
         v = 3'(k);
         do_op(0, {7'd0, v[2]}, {7'd0, v[1]}, v[0], 0);
      end

      do_op(1, 8'h0F, 8'h01, 1'b0, 0);
      do_op(1, 8'h7F, 8'h01, 1'b0, 0);
      do_op(1, 8'hFF, 8'h00, 1'b1, 5);
      do_op(2, 8'hA5, 8'h5A, 1'b1, 0);
      do_op(2, 8'h80, 8'h80, 1'b0, 2);

      // Abort mid-RUN with reset; sum holds partial bits and cout is 1 beforehand.
      set_ops(1, 8'h33, 8'h44);
      cin[1]      = 1'b0;
      in_valid[1] = 1'b1;
      @(posedge clk); #1;
      in_valid[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      chk("abort_out_valid", 32'(out_valid[1]), 32'd0);
      chk("abort_in_ready", 32'(in_ready[1]), 32'd1);
      chk("abort_sum", 32'(s81), 32'd0);
      chk("abort_cout", 32'(cout[1]), 32'd0);
      chk("abort_ovf", 32'(ovf[1]), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      do_op(1, 8'h01, 8'h02, 1'b0, 0);

      for (int k = 0; k < 24; k++) begin
         do_op(k % 3, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 2)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
# serial_adder

Multi-cycle, parametrised adder that computes `sum = a + b + cin` over `WIDTH` bits, processing `DIGIT` bits per clock. It uses a ripple slice of full adders and a registered carry between steps. It sits behind a valid/ready handshake on both sides, so arithmetic datapaths can trade area for latency. With `WIDTH=DIGIT` it degenerates to a registered single-step adder; with `WIDTH=DIGIT=1` it is a registered full adder.

## Interface
Parameters:
- `WIDTH`, 8, operand and sum width in bits, ≥1.
- `DIGIT`, 1, bits added per clock. Must divide `WIDTH`; elaboration error otherwise.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: operands presented.
- `in_ready` out 1: block accepts operands.
- `a` in `WIDTH`: operand A, unsigned or two's complement.
- `b` in `WIDTH`: operand B.
- `cin` in 1: carry in.
- `out_valid` out 1: result presented.
- `out_ready` in 1: consumer takes result.
- `sum` out `WIDTH`: result bits.
- `cout` out 1: carry out of the MSB.
- `ovf` out 1: signed overflow, i.e. carry into MSB XOR carry out of MSB.

## Operation
- `STEPS = WIDTH/DIGIT`. Step counter width is `$clog2(STEPS+1)`.
- States: IDLE, RUN, DONE.
- **IDLE:**
  - `in_ready=1`.
  - On `in_valid&in_ready`: latch `a`, `b`; carry register ← `cin`; counter ← 0; go to RUN.
- **RUN:**
  - Each cycle, add the low `DIGIT` bits of the operand shift registers plus the carry register.
  - Shift the `DIGIT` result bits into the top of the result register; shift the operands right by `DIGIT`.
  - Carry register ← slice carry out.
  - Record the slice's carry into its top bit as `ovf` source.
  - Counter increments. On the step where counter = `STEPS-1`: go to DONE, `cout` ← slice carry out, `ovf` ← carry-into-MSB XOR carry out.
- **DONE:**
  - `out_valid=1`. `sum`, `cout`, `ovf` are held stable.
  - On `out_ready`: go to IDLE.
- `in_ready` is a combinational decode of state==IDLE. `out_valid` is a decode of state==DONE.
- `sum` reflects the internal result shift register, and is meaningful only while `out_valid=1`.
- All arithmetic is modulo 2^`WIDTH`; `cout` carries the 2^`WIDTH` bit.
- `in_valid`, `a`, `b`, `cin` are ignored outside IDLE. `out_ready` is ignored outside DONE.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE, `sum=0`, `cout=0`, `ovf=0`, `out_valid=0`.
  - `in_ready=1` (IDLE decode). Handshakes while `rst=1` are void.
- Latency: operands accepted at edge k → `out_valid` rises after edge k+`STEPS`.
- Throughput: one operation per `STEPS+2` cycles with `out_ready` held high. There is no overlap of accept and deliver.
- Backpressure: `out_valid` stays high and outputs stay stable indefinitely until `out_ready`. `in_ready` stays 0 during that time.
- Reset mid-RUN or mid-DONE aborts the operation: no partial result is emitted, and a new operation may be accepted in the first cycle after deassertion.
- `out_ready` high on the same edge DONE is entered has no effect. It is sampled from the first DONE cycle.

## Structure
- Shared package `adder_pkg`:
  - state enum `{IDLE, RUN, DONE}`.
  - function `steps(WIDTH, DIGIT)`.
- One sub-module `fa_slice`: combinational `DIGIT`-bit ripple of full adders.
  - Inputs: `x`, `y`, `ci`.
  - Outputs: `s`, `co`, `c_msb_in` (carry into the slice's top bit).
  - Instantiated once in `serial_adder`.

## Test plan
- `WIDTH=1, DIGIT=1`, all 8 {a,b,cin} combinations in order 000→111 → `{cout,sum}` = 00,01,01,10,01,10,10,11; `out_valid` 1 cycle after each accept.
- `WIDTH=8, DIGIT=1`, 0x0F+0x01, cin 0 → `sum=0x10`, `cout=0`, `ovf=0`; `out_valid` exactly 8 cycles after accept.
- `WIDTH=8, DIGIT=1`, 0x7F+0x01 → `sum=0x80`, `ovf=1`, `cout=0`. Then 0xFF+0x00 with cin 1 → `sum=0x00`, `cout=1`, `ovf=0`.
- `WIDTH=8, DIGIT=4`, 0xA5+0x5A, cin 1 → `sum=0x00`, `cout=1`; latency 2 cycles.
- Backpressure: hold `out_ready=0` for 5 cycles in DONE → `out_valid=1`, `sum`/`cout` unchanged, `in_ready=0`, and a new `in_valid` is ignored. Releasing `out_ready` → IDLE next cycle.
- Assert `rst` at RUN step 3 of 0x33+0x44 → outputs 0 and state IDLE immediately. Then 0x01+0x02 → `sum=0x03`, with no trace of the aborted operation.
